seq_digit_player: RTL

- Producer side of the seven-segment decoder input. Buffers a memory-game sequence of hex digits (0-F) and plays it back as a timed stream of 5-bit decoder codes.
- Each digit is shown for ON_TICKS ticks, followed by the blank code 5'b10000 for OFF_TICKS ticks.
- Sits between game control (which loads digits and starts playback) and the decoder's 5-bit input.

---
 rtl/seq_digit_player_if.sv | 25 ++
 rtl/seq_digit_player.sv | 137 +++++++++++++
 2 files changed

// File: rtl/seq_digit_player_if.sv
// Game-control <-> digit player bus: load handshake, playback control and decoder-facing status.
interface seq_digit_player_if #(
  parameter int unsigned AW = 4
) ();
  logic          load_valid;
  logic [3:0]    load_digit;
  logic          load_ready;
  logic          clear;
  logic          start;
  logic [4:0]    digit_code;
  logic          busy;
  logic          done;
  logic [AW:0]   count;
  logic [AW-1:0] index;

  modport master (
    output load_valid, load_digit, clear, start,
    input  load_ready, digit_code, busy, done, count, index
  );

  modport slave (
    input  load_valid, load_digit, clear, start,
    output load_ready, digit_code, busy, done, count, index
  );
endinterface

// File: rtl/seq_digit_player.sv
// Buffers a sequence of hex digits and plays it back as timed show/blank 5-bit decoder codes.
module seq_digit_player #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AW        = 4,
  parameter int unsigned ON_TICKS  = 50,
  parameter int unsigned OFF_TICKS = 25,
  parameter int unsigned TW        = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick_en,
  seq_digit_player_if.slave  bus
);

  localparam int unsigned CW    = AW + 1;
  localparam logic [4:0]  Blank = 5'b10000;

  typedef enum logic [1:0] {StIdle, StShow, StGap} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] index_q, index_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [4:0]    code_q, code_d;
  logic          done_q, done_d;
  logic          load_ready;
  logic          load_we;
  logic          last_digit;
  logic [3:0]    mem [DEPTH];

  assign load_ready = (state_q == StIdle) && (count_q < CW'(DEPTH)) && !bus.start && !bus.clear;
  assign last_digit = ({1'b0, index_q} == (count_q - 1'b1));

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    index_d = index_q;
    timer_d = timer_q;
    code_d  = code_q;
    done_d  = 1'b0;
    load_we = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.clear) begin
          count_d = '0;
        end else if (bus.start) begin
          if (count_q == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = StShow;
            index_d = '0;
            timer_d = '0;
            code_d  = {1'b0, mem[0]};
          end
        end else if (bus.load_valid && load_ready) begin
          load_we = 1'b1;
          count_d = count_q + 1'b1;
        end
      end
      StShow: begin
        if (bus.clear) begin
          state_d = StIdle;
          count_d = '0;
          index_d = '0;
          timer_d = '0;
          code_d  = Blank;
        end else if (tick_en) begin
          if (timer_q == TW'(ON_TICKS - 1)) begin
            state_d = StGap;
            timer_d = '0;
            code_d  = Blank;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      StGap: begin
        if (bus.clear) begin
          state_d = StIdle;
          count_d = '0;
          index_d = '0;
          timer_d = '0;
          code_d  = Blank;
        end else if (tick_en) begin
          if (timer_q != TW'(OFF_TICKS - 1)) begin
            timer_d = timer_q + 1'b1;
          end else if (last_digit) begin
            // Final gap has elapsed: report completion once and rewind.
            state_d = StIdle;
            timer_d = '0;
            index_d = '0;
            done_d  = 1'b1;
          end else begin
            state_d = StShow;
            timer_d = '0;
            index_d = index_q + 1'b1;
            code_d  = {1'b0, mem[index_q + 1'b1]};
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      count_q <= '0;
      index_q <= '0;
      timer_q <= '0;
      code_q  <= Blank;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      index_q <= index_d;
      timer_q <= timer_d;
      code_q  <= code_d;
      done_q  <= done_d;
    end
  end

  // Sequence storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (load_we && !reset) begin
      mem[count_q[AW-1:0]] <= bus.load_digit;
    end
  end

  assign bus.load_ready = load_ready;
  assign bus.digit_code = code_q;
  assign bus.busy       = (state_q != StIdle);
  assign bus.done       = done_q;
  assign bus.count      = count_q;
  assign bus.index      = index_q;

endmodule
